// File: rtl/data_width_pkg.sv
// Shared data-path width used across the register-stage blocks.
package data_width_pkg;

  typedef logic [7:0] t_dw;

endpackage

// File: rtl/fifo_sync_pkg.sv
// Types, defaults and helpers for the synchronous FWFT FIFO.
package fifo_sync_pkg;

  typedef data_width_pkg::t_dw t_dw;

  localparam int DEPTH_DEF = 8;
  localparam int CW_DEF    = $clog2(DEPTH_DEF) + 1;

  typedef logic [CW_DEF-1:0] t_cnt;

  // Callers truncate the result to the pointer width, so the wrap is natural.
  function automatic int unsigned f_ptr_inc(input int unsigned ptr);
    return ptr + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x t_dw register array: clocked write, combinational read.
module fifo_mem
  import fifo_sync_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  t_dw           wdata,
  input  logic [AW-1:0] raddr,
  output t_dw           rdata
);

  t_dw mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync.sv
// Single-clock first-word-fall-through FIFO with sticky overflow/underflow flags.
module fifo_sync
  import fifo_sync_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEF,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  t_dw           i_data,
  input  logic          i_pop,
  input  logic          i_clr_err,
  output t_dw           o_data,
  output logic          o_empty,
  output logic          o_full,
  output logic [CW-1:0] o_count,
  output logic          o_ovf,
  output logic          o_udf
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push_ok;
  logic          pop_ok;
  logic          ovf_evt;
  logic          udf_evt;

  // Status is decoded from the count register only, never from the requests.
  assign o_empty = (count == '0);
  assign o_full  = (count == CW'(DEPTH));
  assign o_count = count;

  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
  assign push_ok = i_push & (~o_full | i_pop);
  assign pop_ok  = i_pop & ~o_empty;
  assign ovf_evt = i_push & o_full & ~i_pop;
  assign udf_evt = i_pop & o_empty;

  fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (i_data),
    .raddr (rd_ptr),
    .rdata (o_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      o_ovf  <= 1'b0;
      o_udf  <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= AW'(f_ptr_inc(32'(wr_ptr)));
      end
      if (pop_ok) begin
        rd_ptr <= AW'(f_ptr_inc(32'(rd_ptr)));
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // Set wins over a simultaneous clear.
      o_ovf <= ovf_evt | (o_ovf & ~i_clr_err);
      o_udf <= udf_evt | (o_udf & ~i_clr_err);
    end
  end

endmodule

// File: doc/fifo_sync.md
Name: fifo_sync

Overview:
- Synchronous single-clock FIFO that buffers t_dw words ahead of the data-path register stage.
- Decouples a bursty producer from the downstream register stage, which samples o_data every cycle.
- First-word-fall-through: the head word is visible on o_data whenever o_empty is low.
- Sticky overflow and underflow flags give the bench and software an error indication.

Parameters:
- DEPTH, 8, number of entries. Power of two, DEPTH >= 2.
- CW, $clog2(DEPTH)+1, occupancy counter width. Derived; never overridden.
- Data width comes from t_dw in the shared package (8 bits by default), not from a parameter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- i_push  in  1  write request; i_data is sampled on this cycle's clk edge.
- i_data  in  t_dw  write data.
- i_pop  in  1  read request; retires the head word.
- i_clr_err  in  1  synchronous clear of o_ovf and o_udf.
- o_data  out  t_dw  head word (FWFT).
- o_empty  out  1  count == 0.
- o_full  out  1  count == DEPTH.
- o_count  out  CW  occupancy, 0..DEPTH.
- o_ovf  out  1  sticky: a push was dropped.
- o_udf  out  1  sticky: a pop was attempted while empty.

Behaviour:
- Reset (rst low, asynchronous; released synchronously upstream):
  - wr_ptr = 0, rd_ptr = 0, count = 0, all storage = '0.
  - o_ovf = 0, o_udf = 0, o_empty = 1, o_full = 0, o_data = '0.
  - Reset mid-burst discards all contents immediately; no partial state survives.
- Storage: DEPTH x t_dw register array; write on clk edge only.
- Pointers: log2(DEPTH) bits; increment modulo DEPTH (natural wrap, no compare logic).
- Accept rules, evaluated each rising edge:
  - push_ok = i_push & (!o_full | i_pop)
  - pop_ok = i_pop & !o_empty
- Push while full:
  - With no pop in the same cycle, the word is dropped, o_ovf is set, and count and pointers are unchanged.
  - With a pop in the same cycle, both are accepted and count stays DEPTH.
- Pop while empty:
  - Ignored; o_udf is set.
  - A simultaneous push is still accepted: count becomes 1, and the pushed word appears on o_data the next cycle, not the same cycle.
- Count update:
  - push_ok only: +1.
  - pop_ok only: -1.
  - Both or neither: unchanged.
- o_empty and o_full are decoded from the count register, so they are registered-valid one cycle after the causing edge.
- o_data = storage[rd_ptr] (combinational read of registered storage):
  - Updates the cycle after a pop.
  - Updates the cycle after the first push into an empty FIFO.
  - When empty it shows the stale last entry; consumers must qualify it with !o_empty.
- Latency: a word pushed into an empty FIFO appears on o_data at the next edge (1 cycle).
- Sticky flags: set on an error event, cleared by i_clr_err. If an error and i_clr_err occur in the same cycle, the flag stays set (set wins).
- No combinational path from i_push or i_pop to any output.

Decomposition:
- fifo_sync_pkg:
  - Imports the shared t_dw typedef from the existing data-width package.
  - Defines localparam DEPTH_DEF = 8.
  - Defines typedef t_cnt as logic [CW-1:0] for the default depth.
  - Defines a function f_ptr_inc() for modulo increment.
- Sub-module fifo_mem: DEPTH x t_dw register array with write enable, write address and read address. Async-reset to '0. Instantiated once.
- Top-level fifo_sync holds the pointers, count, flags and accept logic.

Test Plan:
1. Reset then idle, DEPTH=4 → o_empty=1, o_full=0, o_count=0, o_data=8'h00, o_ovf=0, o_udf=0.
2. Push 8'hA1, A2, A3, A4 on consecutive cycles → o_full=1 and o_count=4 after the 4th edge; o_data=8'hA1 from the edge after the first push. Then pop 4 times → o_data sequence A1, A2, A3, A4; o_empty=1 after the last pop.
3. Full FIFO, push 8'hFF without pop → o_ovf=1, o_count stays 4, later pops return A1..A4 and never FF. Repeat with push 8'hB5 and pop together → A1 retired, count 4, B5 read last, o_ovf unchanged.
4. Empty FIFO, pop with simultaneous push 8'h5C → o_udf=1, o_count=1, o_data=8'h5C next cycle. Assert i_clr_err alone → flags clear. Assert i_clr_err in the same cycle as a new underflow → o_udf remains 1.
5. Wrap-around: 10 push/pop pairs of 8'h10..8'h19 with one word resident → output order preserved, o_count constant at 1 across the pointer wrap.
6. Assert rst low mid-burst (count=3, between edges) → all outputs return to reset values immediately. After release, push 8'h77 → o_data=8'h77 with no stale data visible.
